// File: rtl/sap_controller.sv
// -----------------------------------------------------------------------------
// sap_controller
//
// Instruction register and micro-step sequencer for the 8-bit bus computer.
//
// Each clock advances one micro-step. T0/T1 fetch the next instruction into the
// IR, and T2..T4 execute it. Control strobes are decoded combinationally from
// the registered step and IR, so consumers see them for the whole step and act
// on the following posedge. The block drives the IR operand nibble onto the
// shared bus only while an execute step asks for it. At all other times it
// leaves the bus floating.
//
// Parameters
//   STEP_COUNT  micro-steps per instruction without early end (5..8)
//   UNDEF_HALT  1: undefined opcodes behave as HLT, 0: as NOP
//
// Optional feature (compile-time macro SAP_EARLY_END_EN)
//   Defined   : the sequencer returns to T0 right after an instruction's last
//               active step (NOP 2, LDI/JMP/OUT/HLT 3, LDA/STA 4, ADD/SUB 5).
//   Undefined : every instruction takes STEP_COUNT cycles.
//
// Ports
//   clock      system clock, all state changes on posedge
//   reset      asynchronous active-high; clears IR, step counter and halt
//   bus        shared 8-bit data bus (driven as {4'h0, ir[3:0]} when ir_out)
//   pc_out     PC drives bus          pc_inc    PC increments
//   jump       PC loads from bus      mar_in    MAR loads from bus
//   ram_out    RAM drives bus         ram_in    RAM writes from bus
//   a_in       A loads from bus       a_out     A drives bus
//   b_in       B loads from bus       alu_out   ALU drives bus
//   subtract   ALU computes A-B       out_in    output register loads from bus
//   halt       machine halted
//   step       current micro-step (debug)
//   ir_value   IR contents (debug)
// -----------------------------------------------------------------------------
module sap_controller #(
  parameter int STEP_COUNT = 5,
  parameter bit UNDEF_HALT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire  [7:0] bus,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       jump,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       subtract,
  output logic       out_in,
  output logic       halt,
  output logic [2:0] step,
  output logic [7:0] ir_value
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  localparam logic [2:0] LAST_STEP = 3'(STEP_COUNT - 1);
  // Halting freezes the sequencer on the step after T2.
  localparam logic [2:0] HALT_STEP = 3'd3;

  logic [7:0] ir_q;
  logic [2:0] step_q;
  logic       halted_q;

  logic       ir_in;
  logic       ir_out;
  opcode_t    op_cur;
  logic       halt_set;
  logic       end_of_instr;

  // Undefined opcodes collapse onto NOP or HLT so the rest of the decode only
  // has to deal with the defined instruction set.
  function automatic opcode_t decode_op(input logic [3:0] raw);
    case (raw)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE, 4'hF:
        decode_op = opcode_t'(raw);
      default:
        decode_op = UNDEF_HALT ? OP_HLT : OP_NOP;
    endcase
  endfunction

`ifdef SAP_EARLY_END_EN
  // Last step that asserts anything for a given instruction.
  function automatic logic [2:0] last_active_step(input opcode_t op);
    case (op)
      OP_NOP:                         last_active_step = 3'd1;
      OP_LDI, OP_JMP, OP_OUT, OP_HLT: last_active_step = 3'd2;
      OP_LDA, OP_STA:                 last_active_step = 3'd3;
      OP_ADD, OP_SUB:                 last_active_step = 3'd4;
      default:                        last_active_step = LAST_STEP;
    endcase
  endfunction

  // During T1 the IR still holds the previous instruction. A NOP must end
  // at T1, so the length decision looks at the opcode on the bus. This only
  // steers the step counter, never a strobe.
  opcode_t op_len;
  assign op_len       = (step_q == 3'd1) ? decode_op(bus[7:4]) : op_cur;
  assign end_of_instr = (step_q == last_active_step(op_len)) || (step_q == LAST_STEP);
`else
  assign end_of_instr = (step_q == LAST_STEP);
`endif

  assign op_cur   = decode_op(ir_q[7:4]);
  assign halt_set = (step_q == 3'd2) && (op_cur == OP_HLT);

  // Sequencer state: IR, micro-step counter, halt flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q     <= 8'h00;
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      if (ir_in) begin
        ir_q <= bus;
      end
      if (halt_set) begin
        halted_q <= 1'b1;
        step_q   <= HALT_STEP;
      end else if (end_of_instr) begin
        step_q <= 3'd0;
      end else begin
        step_q <= step_q + 3'd1;
      end
    end
  end

  // Microcode: strobes per (step, opcode). All strobes stay low while reset
  // is high or the machine is halted, so nothing moves on the bus.
  always_comb begin
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
    jump     = 1'b0;
    mar_in   = 1'b0;
    ram_out  = 1'b0;
    ram_in   = 1'b0;
    a_in     = 1'b0;
    a_out    = 1'b0;
    b_in     = 1'b0;
    alu_out  = 1'b0;
    subtract = 1'b0;
    out_in   = 1'b0;
    ir_in    = 1'b0;
    ir_out   = 1'b0;
    if (!reset && !halted_q) begin
      case (step_q)
        3'd0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        3'd1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_inc  = 1'b1;
        end
        3'd2: begin
          case (op_cur)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            OP_JMP: begin
              ir_out = 1'b1;
              jump   = 1'b1;
            end
            OP_OUT: begin
              a_out  = 1'b1;
              out_in = 1'b1;
            end
            default: ;
          endcase
        end
        3'd3: begin
          case (op_cur)
            OP_LDA: begin
              ram_out = 1'b1;
              a_in    = 1'b1;
            end
            OP_ADD: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
            end
            OP_SUB: begin
              ram_out  = 1'b1;
              b_in     = 1'b1;
              subtract = 1'b1;
            end
            OP_STA: begin
              a_out  = 1'b1;
              ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        3'd4: begin
          case (op_cur)
            OP_ADD: begin
              alu_out = 1'b1;
              a_in    = 1'b1;
            end
            OP_SUB: begin
              alu_out  = 1'b1;
              a_in     = 1'b1;
              subtract = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus      = ir_out ? {4'h0, ir_q[3:0]} : 8'bz;
  assign halt     = halted_q;
  assign step     = step_q;
  assign ir_value = ir_q;

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Instruction register plus micro-step sequencer for the 8-bit bus computer.
- Latches the fetched instruction from the shared 8-bit bus and decodes it, one micro-step per clock.
- Drives the single-cycle control strobes consumed by the A/B/ALU stage, program counter, MAR, RAM and output register.
- Drives the instruction's operand nibble onto the bus when requested.

Parameters:
- STEP_COUNT, 5, micro-steps per instruction without early end; legal range 5..8.
- UNDEF_HALT, 0, 1 = undefined opcodes act as HLT; 0 = undefined opcodes act as NOP.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; clears IR, step counter, halt.
- bus  inout  8  shared data bus.
- pc_out  output  1  PC drives bus.
- pc_inc  output  1  PC increments.
- jump  output  1  PC loads from bus.
- mar_in  output  1  MAR loads from bus.
- ram_out  output  1  RAM drives bus.
- ram_in  output  1  RAM writes from bus.
- a_in  output  1  A loads from bus.
- a_out  output  1  A drives bus.
- b_in  output  1  B loads from bus.
- alu_out  output  1  ALU drives bus.
- subtract  output  1  ALU computes A-B.
- out_in  output  1  output register loads from bus.
- halt  output  1  machine halted.
- step  output  3  current micro-step, debug.
- ir_value  output  8  IR contents, debug.

Behaviour:
- Reset (async): ir=8'h00, step=0, halted=0. All strobes are 0 and bus is Z while reset is high.
- Strobes are combinational from registered step and ir. No strobe depends on bus. Consumers sample strobes at the next posedge.
- IR loads bus on the posedge ending T1. The new opcode ir[7:4] is therefore visible from T2.
- ir_out is internal only. When asserted, the block drives bus = {4'h0, ir[3:0]}. At all other times the block drives Z.
- Fetch, all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in (internal), pc_inc.
- Execute, by ir[7:4]:
  - 0x0 NOP: no strobes.
  - 0x1 LDA: T2 ir_out+mar_in; T3 ram_out+a_in.
  - 0x2 ADD: T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in.
  - 0x3 SUB: as ADD, with subtract high in T3 and T4.
  - 0x4 STA: T2 ir_out+mar_in; T3 a_out+ram_in.
  - 0x5 LDI: T2 ir_out+a_in.
  - 0x6 JMP: T2 ir_out+jump.
  - 0xE OUT: T2 a_out+out_in.
  - 0xF HLT: T2 sets halted at posedge.
  - Other opcodes: NOP, or HLT when UNDEF_HALT=1.
- Steps beyond T4 (up to STEP_COUNT-1) assert no strobes.
- Step counter: increments each posedge; wraps from STEP_COUNT-1 to 0.
- Halt:
  - Once halted=1, step and ir freeze and all strobes are 0.
  - halt stays 1 until reset; no other exit.
- At most one bus driver per step, guaranteed by the microcode table.
- Reset asserted mid-instruction: immediate return to T0 state; partial instruction abandoned.

Optional Feature:
- Macro: SAP_EARLY_END_EN.
- Defined: after the last active step of an instruction, the next step is T0 (early end).
  - Instruction lengths: NOP 2, LDI/JMP/OUT/HLT 3, LDA/STA 4, ADD/SUB 5 cycles.
- Undefined: every instruction takes STEP_COUNT cycles, idle steps asserting nothing.

Test Plan:
- Reset mid-T3 of LDA (bus 8'h1E fetched) -> step=0, ir_value=8'h00, all strobes 0 in the same cycle as reset, before any clock edge.
- Fetch with RAM model returning 8'h1E, STEP_COUNT=5 -> T0 pc_out+mar_in; T1 ram_out+pc_inc; T2 bus=8'h0E with mar_in; T3 ram_out+a_in; T4 idle; next T0.
- Instruction 8'h3F (SUB 0xF) -> subtract=1 in T3 and T4; alu_out+a_in only in T4; bus=8'h0F in T2 only.
- Instruction 8'h6A (JMP 0xA) -> T2 bus=8'h0A, jump=1; pc_out low. With SAP_EARLY_END_EN, T0 follows at cycle 3.
- Instruction 8'hF0 -> halt=1 after the T2 edge. Step holds at 3 for 20 cycles with strobes 0 and bus Z. Reset clears halt.
- Opcode 8'h90 with UNDEF_HALT=0 -> behaves as NOP. With UNDEF_HALT=1 -> halt=1 after T2.
